// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly job dispatcher.
package butterfly_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned MODE_W = 5;
  localparam int unsigned DESC_W = LEN_W + MODE_W;

  localparam int unsigned MODE_FFT        = 0;
  localparam int unsigned MODE_BYPASS_P2S = 1;
  localparam int unsigned MODE_SC_ADD     = 2;
  localparam int unsigned MODE_SC_CACHE   = 3;
  localparam int unsigned MODE_LN         = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [LEN_W-1:0]  len;
  } cmd_desc_t;

endpackage

// File: rtl/dispatch_cmd_fifo.sv
// Synchronous FIFO with first-word fall-through read data and registered flags.
module dispatch_cmd_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_d;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is allowed only when a read frees the slot this cycle.
  assign do_rd     = rd_en && !empty;
  assign do_wr     = wr_en && (!full || do_rd);
  assign count_d   = count + CW'(do_wr) - CW'(do_rd);
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/butterfly_job_dispatcher.sv
// Job front end: queues descriptors, fans config out to engine groups,
// gates input beats and counts output beats to detect job completion.
module butterfly_job_dispatcher
  import butterfly_pkg::*;
#(
  parameter int unsigned NUM_GROUPS = 32,
  parameter int unsigned IN_CHNL    = 8,
  parameter int unsigned OUT_CHNL   = 8,
  parameter int unsigned CMD_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_vld,
  input  logic [LEN_W-1:0]             cmd_len,
  input  logic [MODE_W-1:0]            cmd_mode,
  output logic                         cmd_rdy,
  output logic [NUM_GROUPS*LEN_W-1:0]  cfg_length,
  output logic [NUM_GROUPS*MODE_W-1:0] cfg_mode,
  output logic [NUM_GROUPS-1:0]        bu_start,
  input  logic [IN_CHNL-1:0]           up_vld,
  output logic [IN_CHNL-1:0]           up_rdy,
  output logic [IN_CHNL-1:0]           eng_up_vld,
  input  logic                         eng_up_rdy,
  input  logic [OUT_CHNL-1:0]          eng_dn_vld,
  input  logic [OUT_CHNL-1:0]          dn_rdy,
  output logic                         busy,
  output logic                         done,
  output logic [LEN_W-1:0]             in_cnt
);

  state_e            state_q;
  state_e            state_d;
  logic [DESC_W-1:0] head_raw;
  cmd_desc_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              start_d;
  logic              done_d;
  logic              in_run;
  logic              in_beat;
  logic              out_beat;
  logic [LEN_W-1:0]  job_len_q;
  logic [LEN_W-1:0]  out_cnt_q;
  logic [LEN_W-1:0]  out_cnt_d;
  logic [LEN_W-1:0]  in_cnt_d;

  assign cmd_rdy = !fifo_full;
  assign push    = cmd_vld && cmd_rdy;
  assign head    = cmd_desc_t'(head_raw);

  dispatch_cmd_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (push),
    .wr_data   ({cmd_mode, cmd_len}),
    .rd_en     (pop),
    .rd_data_c (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Joint input handshake: only a beat valid on every channel is forwarded.
  assign in_run     = (state_q == S_RUN);
  assign up_rdy     = in_run ? {IN_CHNL{eng_up_rdy}} : '0;
  assign eng_up_vld = (in_run && (&up_vld)) ? up_vld : '0;
  assign in_beat    = in_run && (&up_vld) && eng_up_rdy;

  // Output beats count in RUN and DRAIN, saturating at the job length.
  assign out_beat = ((state_q == S_RUN) || (state_q == S_DRAIN))
                    && (&(eng_dn_vld & dn_rdy))
                    && (out_cnt_q != job_len_q);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    in_cnt_d  = in_cnt + LEN_W'(in_beat);
    out_cnt_d = out_cnt_q + LEN_W'(out_beat);

    case (state_q)
      S_IDLE: begin
        // The done cycle keeps the FSM idle so jobs are always separated.
        if (!fifo_empty && !done) begin
          pop = 1'b1;
          if (head.len != '0) begin
            state_d = S_LOAD;
            start_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (in_beat && (in_cnt_d == job_len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_d == job_len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      job_len_q  <= '0;
      in_cnt     <= '0;
      out_cnt_q  <= '0;
      cfg_length <= '0;
      cfg_mode   <= '0;
      bu_start   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt    <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      bu_start  <= {NUM_GROUPS{start_d}};
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      // Every group copy loads on the pop edge and holds until the next pop.
      if (pop) begin
        job_len_q  <= head.len;
        cfg_length <= {NUM_GROUPS{head.len}};
        cfg_mode   <= {NUM_GROUPS{head.mode}};
      end
    end
  end

endmodule

// File: doc/butterfly_job_dispatcher.md
Name: butterfly_job_dispatcher

Overview:
Per-job control front end for the next-generation butterfly processor. It queues job descriptors (length plus mode bits) and replicates the active configuration to NUM_GROUPS engine groups through registered copies, so no single flop drives the whole array. It also issues the per-job start pulse, gates input beats across IN_CHNL AXI channels with a joint handshake, and counts output beats across OUT_CHNL channels to detect job completion. It sits between the host command interface and the array of butterfly engines and weight buffers.

Parameters:
NUM_GROUPS, 32, number of engine groups receiving a config copy and a start pulse
IN_CHNL, 8, number of input AXI channels
OUT_CHNL, 8, number of output AXI channels
LEN_W, 16, job length width (beats)
MODE_W, 5, mode bits {is_ln, is_sc_cache, is_sc_add, is_bypass_p2s, is_fft} (MSB to LSB)
CMD_DEPTH, 4, descriptor FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
cmd_vld  in  1  descriptor valid
cmd_len  in  LEN_W  job length in beats
cmd_mode  in  MODE_W  job mode bits
cmd_rdy  out  1  descriptor FIFO not full
cfg_length  out  NUM_GROUPS*LEN_W  replicated length; group g at [g*LEN_W +: LEN_W]
cfg_mode  out  NUM_GROUPS*MODE_W  replicated mode bits
bu_start  out  NUM_GROUPS  one-cycle start pulse per group
up_vld  in  IN_CHNL  source valid per input channel
up_rdy  out  IN_CHNL  ready to source; all bits identical
eng_up_vld  out  IN_CHNL  gated valid to the engines
eng_up_rdy  in  1  engine array ready
eng_dn_vld  in  OUT_CHNL  engine output valid per channel
dn_rdy  in  OUT_CHNL  downstream ready per channel
busy  out  1  a job is in LOAD, RUN or DRAIN
done  out  1  one-cycle pulse at job completion
in_cnt  out  LEN_W  accepted input beats of the current job

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; state IDLE.
  - cfg_length, cfg_mode, bu_start, up_rdy, eng_up_vld, busy, done and in_cnt all go to 0.
  - cmd_rdy is 1 one cycle after rst_n deasserts.
  - Reset mid-job aborts the job: no done pulse, no start pulse.
- Descriptor FIFO:
  - Push when cmd_vld && cmd_rdy.
  - cmd_rdy = !full.
  - A push and a pop in the same cycle are both legal when full.
  - A push and a pop are also both legal when empty; the pushed entry is not poppable until the next cycle.
- FSM IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
  - IDLE: if FIFO non-empty, pop it and register len/mode into all NUM_GROUPS copies. The copies are updated on the same edge, so all groups match in the cycle after the pop.
    - If popped len==0: assert done the next cycle, skip LOAD/RUN/DRAIN, leave cfg_* updated, issue no bu_start.
    - Otherwise go to LOAD.
  - LOAD: bu_start = all-ones for exactly this cycle, then go to RUN. cfg_* remain stable from LOAD until the next pop.
  - RUN: beat accepted when &up_vld && eng_up_rdy.
    - up_rdy = {IN_CHNL{eng_up_rdy}} in RUN only; 0 in all other states.
    - eng_up_vld = up_vld when &up_vld in RUN, else 0. Partial valid is never forwarded.
    - in_cnt increments per accepted beat. On the beat where in_cnt==len-1, go to DRAIN.
  - DRAIN: output beat counted when &(eng_dn_vld & dn_rdy). The counter is out_cnt, internal, LEN_W bits.
    - Output beats are also counted during RUN.
    - When out_cnt reaches len (including the case where it reached len in the same cycle RUN exits), assert done for 1 cycle and return to IDLE.
    - in_cnt and out_cnt clear on IDLE entry.
- busy = state != IDLE.
- Back-to-back jobs: from done, the next pop can occur no earlier than the following cycle (IDLE), so there is at least one idle cycle between jobs.
- Counters are LEN_W bits wide; len = 2^LEN_W-1 is the maximum and is legal; counters never wrap within a job.

Decomposition:
- Shared package butterfly_pkg holds:
  - LEN_W, MODE_W
  - mode bit index constants MODE_FFT=0, MODE_BYPASS_P2S=1, MODE_SC_ADD=2, MODE_SC_CACHE=3, MODE_LN=4
  - state encoding localparams S_IDLE, S_LOAD, S_RUN, S_DRAIN
- One sub-module: dispatch_cmd_fifo (synchronous FIFO, parameters width and depth, with full/empty outputs).

Test Plan:
- Reset, then push {len=4, mode=5'b00001}. Then:
  - bu_start=32'hFFFFFFFF for exactly 1 cycle;
  - every cfg_length slice=4;
  - with up_vld=8'hFF and eng_up_rdy=1 held, in_cnt goes 1,2,3,4;
  - done pulses 1 cycle after the 4th output beat.
- up_vld=8'h7F for 3 cycles, then 8'hFF: eng_up_vld=0 and in_cnt unchanged during the 3 cycles; beat accepted on the 4th cycle.
- Push len=0: done pulses 1 cycle after the pop, bu_start is never asserted, busy stays 0.
- Push 5 descriptors with CMD_DEPTH=4 and no pops: cmd_rdy=0 after the 4th push. The jobs then execute in FIFO order, verified through cfg_length values 1,2,3,4 then 5.
- Drop dn_rdy[3] mid-DRAIN for 5 cycles: out_cnt holds and done is delayed exactly 5 cycles.
- Assert rst_n=0 during RUN at in_cnt=2: the next cycle shows busy=0, in_cnt=0, cmd_rdy=1, and no done pulse.
